// File: rtl/serial_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_byte_tx
//  Description : UART-style serial transmitter. Frames are start, LSB-first
//                payload, optional parity, and stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy
);

    localparam int                 CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         C_BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic               C_PAR_EN   = (PARITY == 1) || (PARITY == 2);
    localparam logic               C_PAR_ODD  = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cyc_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx_out;
    logic                 w_bit_end;

    assign w_bit_end = (r_cyc_cnt == C_CNT_LAST);

    // tx_out is loaded with the next bit value on each transition edge, so
    // the line never depends combinationally on the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tx_out  <= 1'b1;
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx_out  <= 1'b1;
                    r_cyc_cnt <= '0;
                    if (tx_valid) begin
                        r_shift  <= tx_data;
                        r_parity <= (^tx_data) ^ C_PAR_ODD;
                        r_tx_out <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_tx_out  <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        if (r_bit_cnt == C_BIT_LAST) begin
                            if (C_PAR_EN) begin
                                r_tx_out <= r_parity;
                                r_state  <= S_PARITY;
                            end else begin
                                r_tx_out <= 1'b1;
                                r_state  <= S_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx_out  <= r_shift[1];
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        r_tx_out  <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= '0;
                        r_tx_out  <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cyc_cnt <= '0;
                    r_tx_out  <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_out   = r_tx_out;
    assign tx_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_tx.sv
`default_nettype none
// Bench for serial_byte_tx: four instances (divider 4 with no/even/odd parity,
// divider 2 with no parity) checked cycle by cycle against a frame model.
module tb_serial_byte_tx;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   tx_valid;
    logic [N-1:0]   tx_ready;
    logic [N-1:0]   tx_out;
    logic [N-1:0]   busy;
    logic [7:0]     tx_data [N];

    int vectors     = 0;
    int miscompares = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            serial_byte_tx #(
                .CLKS_PER_BIT (g == 3 ? 2 : 4),
                .DATA_BITS    (8),
                .PARITY       (g == 1 ? 1 : (g == 2 ? 2 : 0))
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .tx_data  (tx_data[g]),
                .tx_valid (tx_valid[g]),
                .tx_ready (tx_ready[g]),
                .tx_out   (tx_out[g]),
                .busy     (busy[g])
            );
        end
    endgenerate

    function automatic int cpb(input int i);
        return (i == 3) ? 2 : 4;
    endfunction

    function automatic int par(input int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    // Expected line level for every cycle of one frame.
    task automatic build_frame(input int i, input logic [7:0] d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (par(i) == 1) bits.push_back(^d);
        else if (par(i) == 2) bits.push_back(~^d);
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[k]) repeat (cpb(i)) exp_q.push_back(bits[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int i, input string tag);
        vectors++;
        assert ({tx_out[i], busy[i], tx_ready[i]} === 3'b101) else begin
            miscompares++;
            $error("FAIL %s dut%0d: out/busy/ready observed %b expected 101", tag, i,
                   {tx_out[i], busy[i], tx_ready[i]});
        end
    endtask

    task automatic check_all_idle(input string tag);
        for (int i = 0; i < N; i++) check_idle(i, tag);
    endtask

    task automatic wait_ready(input int i);
        int k = 0;
        while (tx_ready[i] !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        vectors++;
        assert (tx_ready[i] === 1'b1) else begin
            miscompares++;
            $error("FAIL ready_timeout dut%0d: observed %b expected 1", i, tx_ready[i]);
        end
    endtask

    // mode 0: one-cycle valid, random junk on tx_data during the frame.
    // mode 1: valid held high, 0xFF shown mid-frame, then nxt presented.
    task automatic send_frame(input int i, input logic [7:0] d, input int mode,
                              input logic [7:0] nxt);
        wait_ready(i);
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        tick();
        build_frame(i, d);
        for (int n = 0; n < exp_q.size(); n++) begin
            if (mode == 0) begin
                tx_valid[i] = 1'b0;
                tx_data[i]  = 8'($urandom);
            end else begin
                tx_data[i] = (n >= exp_q.size() / 3 && n < exp_q.size() / 2) ? 8'hFF : nxt;
            end
            vectors++;
            assert ({tx_out[i], busy[i], tx_ready[i]} === {exp_q[n], 2'b10}) else begin
                miscompares++;
                $error("FAIL frame dut%0d data %h cycle %0d: observed %b expected %b",
                       i, d, n, {tx_out[i], busy[i], tx_ready[i]}, {exp_q[n], 2'b10});
            end
            tick();
        end
        check_idle(i, $sformatf("post_frame_%h", d));
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = '0;
        for (int i = 0; i < N; i++) tx_data[i] = 8'h00;

        repeat (3) begin
            tick();
            check_all_idle("reset");
        end
        rst = 1'b0;
        repeat (20) begin
            tick();
            check_all_idle("idle");
        end

        send_frame(0, 8'h55, 0, 8'h00);
        send_frame(1, 8'h07, 0, 8'h00);
        send_frame(2, 8'h07, 0, 8'h00);

        // Back-to-back with a single idle cycle between frames.
        send_frame(0, 8'hA3, 1, 8'h3C);
        send_frame(0, 8'h3C, 0, 8'h00);
        tick();
        check_idle(0, "after_b2b");

        // Reset during the third data bit, with valid asserted during reset.
        tx_data[0]  = 8'h00;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        repeat (13) tick();
        vectors++;
        assert ({tx_out[0], busy[0]} === 2'b01) else begin
            miscompares++;
            $error("FAIL pre_reset_bit: observed %b expected 01", {tx_out[0], busy[0]});
        end
        rst         = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h5A;
        tick();
        check_idle(0, "reset_edge");
        tick();
        check_idle(0, "reset_valid_ignored");
        rst         = 1'b0;
        tx_valid[0] = 1'b0;
        tick();
        check_idle(0, "after_reset");
        send_frame(0, 8'h81, 0, 8'h00);

        send_frame(3, 8'hF0, 0, 8'h00);

        for (int r = 0; r < 12; r++) begin
            int         i;
            logic [7:0] d;
            i = int'($urandom_range(0, N - 1));
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check_idle(i, "random_gap");
            end
            send_frame(i, d, 0, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
